score_bcd: RTL and testbench

- Sequential binary-to-BCD converter (iterative double-dabble) that turns the game's binary score/line count into four decimal digits.
- The four digits feed the four-digit multiplexed seven-segment driver's digit inputs.
- Outputs hold the last converted value between conversions, so the display never shows intermediate shift states.
- An out-of-range value produces the dash code on all four digits. The display driver renders any digit code above 9 as a dash.

---
 rtl/score_bcd.sv | 116 +++++++++++
 tb/tb_score_bcd.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/score_bcd.sv
// score_bcd: iterative double-dabble binary-to-BCD converter for the
// four-digit score display. One shift per clock, BIN_W clocks per value.
// Digits and ovf only change on the done edge, so the display never sees
// partial shift states. Values above 9999 show as dashes (4'hA).
module score_bcd #(
    parameter int BIN_W = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic [3:0]       d0,
    output logic [3:0]       d1,
    output logic [3:0]       d2,
    output logic [3:0]       d3,
    output logic             busy,
    output logic             done,
    output logic             ovf
);

    // Counter only has to reach BIN_W-1; keep it at least one bit wide.
    localparam int CNT_W = (BIN_W < 2) ? 1 : $clog2(BIN_W);

    typedef enum logic {IDLE, CONV} state_t;

    state_t                 state_q, state_d;
    logic [BIN_W-1:0]       shift_q;
    logic [15:0]            bcd_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   ovf_pend_q;
    logic [3:0][3:0]        dig_q;
    logic                   ovf_q;
    logic                   done_q;

    logic [15:0]            bcd_adj;
    logic [15:0]            bcd_d;
    logic [BIN_W-1:0]       shift_d;
    logic                   last;
    logic                   accept;
    logic                   in_range;

    assign last     = (cnt_q == CNT_W'(BIN_W - 1));
    assign accept   = (state_q == IDLE) && start;
    assign in_range = (32'(bin) <= 32'd9999);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: leave IDLE on start, return after the final shift.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CONV;
            CONV:    if (last)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy = (state_q == CONV);
    end

    // One double-dabble step: add 3 to each nibble >= 5 (no inter-nibble
    // carry), then shift {bcd, shift} left by one.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
    end

    // Datapath: load on accept, shift in CONV, publish result on the last shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q    <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            dig_q      <= '0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                shift_q    <= bin;
                bcd_q      <= '0;
                cnt_q      <= '0;
                ovf_pend_q <= !in_range;
            end else if (state_q == CONV) begin
                shift_q <= shift_d;
                bcd_q   <= bcd_d;
                cnt_q   <= cnt_q + 1'b1;
                if (last) begin
                    done_q <= 1'b1;
                    ovf_q  <= ovf_pend_q;
                    if (ovf_pend_q) dig_q <= {4{4'hA}};
                    else            dig_q <= bcd_d;
                end
            end
        end
    end

    assign d0   = dig_q[0];
    assign d1   = dig_q[1];
    assign d2   = dig_q[2];
    assign d3   = dig_q[3];
    assign done = done_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_score_bcd.sv
// Bench for score_bcd: table of conversions plus hand-built sequences for
// back-to-back, ignored start, mid-conversion reset and bin changes.
// Expected results go into a queue at stimulus time and are popped on done.
module tb_score_bcd;

    localparam int BIN_W = 14;

    typedef struct packed {
        logic [3:0] d3, d2, d1, d0;
        logic       ovf;
    } exp_t;

    typedef struct {
        logic [BIN_W-1:0] b;
        exp_t             e;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [BIN_W-1:0] bin = '0;
    logic [3:0]       d0, d1, d2, d3;
    logic             busy, done, ovf;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb[$];
    int   done_cyc[$];

    score_bcd #(.BIN_W(BIN_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .busy(busy), .done(done), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest queued expectation.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (rst_n && done) begin
            done_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done with empty scoreboard at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", 32'({d3, d2, d1, d0, ovf}), 32'(e));
            end
        end
    end

    function automatic exp_t mk(input int a, input int b, input int c, input int d, input bit o);
        exp_t e;
        e.d3 = 4'(a); e.d2 = 4'(b); e.d1 = 4'(c); e.d0 = 4'(d); e.ovf = o;
        return e;
    endfunction

    // Single conversion; bin is scrambled right after accept to prove latching.
    task automatic convert(input logic [BIN_W-1:0] b, input exp_t e);
        int lat;
        bit got;
        @(negedge clk);
        start = 1'b1;
        bin   = b;
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        bin   = BIN_W'($urandom);
        chk("busy_after_accept", 32'(busy), 32'd1);
        lat = 0;
        got = 0;
        while (!got && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (done) got = 1;
        end
        chk("done_seen", 32'(got), 32'd1);
        chk("latency", 32'(lat), 32'(BIN_W));
        chk("busy_at_done", 32'(busy), 32'd0);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, 32'(done), 32'd1);
    endtask

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{14'd1234,  mk(1, 2, 3, 4, 0)};
        vecs[1]  = '{14'd0,     mk(0, 0, 0, 0, 0)};
        vecs[2]  = '{14'd9999,  mk(9, 9, 9, 9, 0)};
        vecs[3]  = '{14'd10000, mk(10, 10, 10, 10, 1)};
        vecs[4]  = '{14'd16383, mk(10, 10, 10, 10, 1)};
        vecs[5]  = '{14'd42,    mk(0, 0, 4, 2, 0)};
        vecs[6]  = '{14'd1,     mk(0, 0, 0, 1, 0)};
        vecs[7]  = '{14'd10,    mk(0, 0, 1, 0, 0)};
        vecs[8]  = '{14'd99,    mk(0, 0, 9, 9, 0)};
        vecs[9]  = '{14'd5005,  mk(5, 0, 0, 5, 0)};
        vecs[10] = '{14'd8765,  mk(8, 7, 6, 5, 0)};
        vecs[11] = '{14'd7089,  mk(7, 0, 8, 9, 0)};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_digits", 32'({d3, d2, d1, d0}), 32'h0);
        chk("reset_flags", 32'({busy, done, ovf}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_release_idle", 32'({busy, done, ovf}), 32'h0);

        // Table-driven conversions.
        for (int i = 0; i < 12; i++) convert(vecs[i].b, vecs[i].e);

        // Back-to-back with start held: 0 then 9999, dones 15 cycles apart.
        @(negedge clk);
        done_cyc.delete();
        start = 1'b1;
        bin   = 14'd0;
        sb.push_back(mk(0, 0, 0, 0, 0));
        sb.push_back(mk(9, 9, 9, 9, 0));
        @(posedge clk);
        @(negedge clk);
        bin = 14'd9999;
        wait_done("b2b_first_done");
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_second_accept", 32'(busy), 32'd1);
        wait_done("b2b_second_done");
        @(posedge clk); #1;
        chk("b2b_done_count", 32'(done_cyc.size()), 32'd2);
        if (done_cyc.size() == 2)
            chk("b2b_spacing", 32'(done_cyc[1] - done_cyc[0]), 32'(BIN_W + 1));

        // Overflow clears on a following in-range value.
        convert(14'd10000, mk(10, 10, 10, 10, 1));
        convert(14'd42, mk(0, 0, 4, 2, 0));

        // Start while busy is ignored: one done, 0500.
        @(negedge clk);
        done_cyc.delete();
        start = 1'b1;
        bin   = 14'd500;
        sb.push_back(mk(0, 5, 0, 0, 0));
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        bin   = 14'd777;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore_done");
        repeat (20) @(posedge clk);
        #1;
        chk("ignore_no_rebusy", 32'(busy), 32'd0);
        chk("ignore_done_count", 32'(done_cyc.size()), 32'd1);

        // Reset mid-conversion: outputs clear at once, no done.
        convert(14'd8888, mk(8, 8, 8, 8, 0));
        @(negedge clk);
        done_cyc.delete();
        start = 1'b1;
        bin   = 14'd123;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_digits", 32'({d3, d2, d1, d0}), 32'h0);
        chk("midrst_flags", 32'({busy, done, ovf}), 32'h0);
        repeat (20) @(posedge clk);
        #1;
        chk("midrst_no_done", 32'(done_cyc.size()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        convert(14'd123, mk(0, 1, 2, 3, 0));

        // bin changes after accept are ignored.
        @(negedge clk);
        start = 1'b1;
        bin   = 14'd321;
        sb.push_back(mk(0, 3, 2, 1, 0));
        @(negedge clk);
        start = 1'b0;
        bin   = 14'd999;
        wait_done("latch_done");
        repeat (3) @(posedge clk);
        #1;
        chk("latch_hold", 32'({d3, d2, d1, d0}), 32'h0321);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
